// File: rtl/uibi_pkg.sv
// Shared definitions for the unisys internal bus (UIBI).
// Holds the default bus geometry, the arbiter FSM state type and the
// byte-lane mode encodings used by masters and slaves.
package uibi_pkg;

    localparam int UIBI_XLEN        = 32;
    localparam int UIBI_SLAVE_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } uibi_state_t;

    localparam logic [2:0] UIBI_MODE_WORD = 3'b111;
    localparam logic [2:0] UIBI_MODE_HALF = 3'b011;
    localparam logic [2:0] UIBI_MODE_BYTE = 3'b001;

endpackage

// File: rtl/uibi_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the most recently granted requester
//   valid      - at least one request is pending
//   idx        - winner: first requester found searching from last_grant+1, wrapping
module uibi_rr_picker
    import uibi_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic          hi_valid_s;
    logic          lo_valid_s;
    logic [IW-1:0] hi_idx_s;
    logic [IW-1:0] lo_idx_s;

    // Lowest requester above last_grant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        hi_valid_s = 1'b0;
        lo_valid_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        // Scanning downwards leaves the lowest matching index in each half.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last_grant)) begin
                    hi_valid_s = 1'b1;
                    hi_idx_s   = IW'(i);
                end else begin
                    lo_valid_s = 1'b1;
                    lo_idx_s   = IW'(i);
                end
            end else begin
                hi_valid_s = hi_valid_s;
            end
        end
        valid = hi_valid_s | lo_valid_s;
        if (hi_valid_s) begin
            idx = hi_idx_s;
        end else begin
            idx = lo_idx_s;
        end
    end

endmodule

// File: rtl/uibi_arbiter.sv
// Shared-bus arbiter and slave router for the unisys internal bus.
// Grants one of MASTER_NUM masters round-robin, latches its transaction,
// forwards it to the slave chosen by the latched slave index, and returns
// read data plus a one-cycle ready pulse to the granted master. Unmapped
// slave indices and slaves that stall beyond TIMEOUT are answered with 0.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   master_dat_i/addr/num/wen/mode - per-master transaction fields
//   master_req                     - per-master request, held until ready
//   master_dat_o, master_ready     - response data (broadcast) and ready pulse
//   slave_dat_o/addr/wen/mode      - latched fields broadcast to every slave
//   slave_req                      - one-hot request to the selected slave
//   slave_dat_i, slave_ready       - per-slave read data and completion
module uibi_arbiter
    import uibi_pkg::*;
#(
    parameter int XLEN        = UIBI_XLEN,
    parameter int SLAVE_WIDTH = UIBI_SLAVE_WIDTH,
    parameter int MASTER_NUM  = 2,
    parameter int SLAVE_NUM   = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [MASTER_NUM*XLEN-1:0]             master_dat_i,
    output logic [MASTER_NUM*XLEN-1:0]             master_dat_o,
    input  logic [MASTER_NUM*(XLEN-SLAVE_WIDTH)-1:0] master_addr,
    input  logic [MASTER_NUM*SLAVE_WIDTH-1:0]      master_num,
    input  logic [MASTER_NUM-1:0]                  master_req,
    input  logic [MASTER_NUM-1:0]                  master_wen,
    input  logic [MASTER_NUM*3-1:0]                master_mode,
    output logic [MASTER_NUM-1:0]                  master_ready,
    output logic [SLAVE_NUM*XLEN-1:0]              slave_dat_o,
    input  logic [SLAVE_NUM*XLEN-1:0]              slave_dat_i,
    output logic [SLAVE_NUM*(XLEN-SLAVE_WIDTH)-1:0] slave_addr,
    output logic [SLAVE_NUM-1:0]                   slave_req,
    output logic [SLAVE_NUM-1:0]                   slave_wen,
    output logic [SLAVE_NUM*3-1:0]                 slave_mode,
    input  logic [SLAVE_NUM-1:0]                   slave_ready
);

    localparam int AW  = XLEN - SLAVE_WIDTH;
    localparam int MIW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
    localparam int CW  = $clog2(TIMEOUT + 2);
    localparam logic [SLAVE_WIDTH:0] SLAVE_LIMIT = (SLAVE_WIDTH + 1)'(SLAVE_NUM);

    uibi_state_t            state_r, state_nx_s;
    logic [MIW-1:0]         grant_r, grant_nx_s;
    logic [MIW-1:0]         last_grant_r, last_grant_nx_s;
    logic [CW-1:0]          cnt_r, cnt_nx_s;
    logic [AW-1:0]          addr_r, addr_nx_s;
    logic [SLAVE_WIDTH-1:0] num_r, num_nx_s;
    logic                   wen_r, wen_nx_s;
    logic [2:0]             mode_r, mode_nx_s;
    logic [XLEN-1:0]        wdat_r, wdat_nx_s;
    logic [XLEN-1:0]        rdata_r, rdata_nx_s;
    logic [SLAVE_NUM-1:0]   slave_req_r, slave_req_nx_s;
    logic [MASTER_NUM-1:0]  master_ready_r, master_ready_nx_s;

    logic                   pick_valid_s;
    logic [MIW-1:0]         pick_idx_s;
    logic [AW-1:0]          win_addr_s;
    logic [SLAVE_WIDTH-1:0] win_num_s;
    logic                   win_wen_s;
    logic [2:0]             win_mode_s;
    logic [XLEN-1:0]        win_dat_s;
    logic                   sel_ready_s;
    logic [XLEN-1:0]        sel_dat_s;

    uibi_rr_picker #(
        .N  (MASTER_NUM),
        .IW (MIW)
    ) u_picker (
        .req        (master_req),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .idx        (pick_idx_s)
    );

    // Route the picked master's request fields toward the transaction latches.
    always_comb begin
        win_addr_s = '0;
        win_num_s  = '0;
        win_wen_s  = 1'b0;
        win_mode_s = 3'b000;
        win_dat_s  = '0;
        for (int m = 0; m < MASTER_NUM; m++) begin
            if (pick_idx_s == MIW'(m)) begin
                win_addr_s = master_addr[m*AW +: AW];
                win_num_s  = master_num[m*SLAVE_WIDTH +: SLAVE_WIDTH];
                win_wen_s  = master_wen[m];
                win_mode_s = master_mode[m*3 +: 3];
                win_dat_s  = master_dat_i[m*XLEN +: XLEN];
            end else begin
                win_wen_s = win_wen_s;
            end
        end
    end

    // Select ready and read data of the latched slave; other slaves are ignored.
    always_comb begin
        sel_ready_s = 1'b0;
        sel_dat_s   = '0;
        for (int s = 0; s < SLAVE_NUM; s++) begin
            if (num_r == SLAVE_WIDTH'(s)) begin
                sel_ready_s = slave_ready[s];
                sel_dat_s   = slave_dat_i[s*XLEN +: XLEN];
            end else begin
                sel_ready_s = sel_ready_s;
            end
        end
    end

    // Next-state logic plus next values of the registered request/ready outputs.
    always_comb begin
        state_nx_s      = state_r;
        grant_nx_s      = grant_r;
        last_grant_nx_s = last_grant_r;
        cnt_nx_s        = cnt_r;
        addr_nx_s       = addr_r;
        num_nx_s        = num_r;
        wen_nx_s        = wen_r;
        mode_nx_s       = mode_r;
        wdat_nx_s       = wdat_r;
        rdata_nx_s      = rdata_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_nx_s      = pick_idx_s;
                    last_grant_nx_s = pick_idx_s;
                    cnt_nx_s        = '0;
                    addr_nx_s       = win_addr_s;
                    num_nx_s        = win_num_s;
                    wen_nx_s        = win_wen_s;
                    mode_nx_s       = win_mode_s;
                    wdat_nx_s       = win_dat_s;
                    if ({1'b0, win_num_s} < SLAVE_LIMIT) begin
                        state_nx_s = BUSY;
                    end else begin
                        // Nothing lives at this index: answer immediately with 0.
                        state_nx_s = RESP;
                        rdata_nx_s = '0;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (sel_ready_s) begin
                    state_nx_s = RESP;
                    if (wen_r) begin
                        rdata_nx_s = '0;
                    end else begin
                        rdata_nx_s = sel_dat_s;
                    end
                end else if (cnt_r == CW'(TIMEOUT)) begin
                    state_nx_s = RESP;
                    rdata_nx_s = '0;
                end else begin
                    cnt_nx_s = cnt_r + CW'(1);
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered.
        slave_req_nx_s    = '0;
        master_ready_nx_s = '0;
        for (int s = 0; s < SLAVE_NUM; s++) begin
            if ((state_nx_s == BUSY) && (num_nx_s == SLAVE_WIDTH'(s))) begin
                slave_req_nx_s[s] = 1'b1;
            end else begin
                slave_req_nx_s[s] = 1'b0;
            end
        end
        for (int m = 0; m < MASTER_NUM; m++) begin
            if ((state_nx_s == RESP) && (grant_nx_s == MIW'(m))) begin
                master_ready_nx_s[m] = 1'b1;
            end else begin
                master_ready_nx_s[m] = 1'b0;
            end
        end
    end

    // FSM state, transaction latches and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            grant_r        <= '0;
            last_grant_r   <= MIW'(MASTER_NUM - 1);
            cnt_r          <= '0;
            addr_r         <= '0;
            num_r          <= '0;
            wen_r          <= 1'b0;
            mode_r         <= 3'b000;
            wdat_r         <= '0;
            rdata_r        <= '0;
            slave_req_r    <= '0;
            master_ready_r <= '0;
        end else begin
            state_r        <= state_nx_s;
            grant_r        <= grant_nx_s;
            last_grant_r   <= last_grant_nx_s;
            cnt_r          <= cnt_nx_s;
            addr_r         <= addr_nx_s;
            num_r          <= num_nx_s;
            wen_r          <= wen_nx_s;
            mode_r         <= mode_nx_s;
            wdat_r         <= wdat_nx_s;
            rdata_r        <= rdata_nx_s;
            slave_req_r    <= slave_req_nx_s;
            master_ready_r <= master_ready_nx_s;
        end
    end

    assign master_dat_o = {MASTER_NUM{rdata_r}};
    assign master_ready = master_ready_r;
    assign slave_req    = slave_req_r;
    assign slave_dat_o  = {SLAVE_NUM{wdat_r}};
    assign slave_addr   = {SLAVE_NUM{addr_r}};
    assign slave_wen    = {SLAVE_NUM{wen_r}};
    assign slave_mode   = {SLAVE_NUM{mode_r}};

endmodule

// File: tb/tb_uibi_arbiter.sv
// Self-checking bench for uibi_arbiter: reactive slave models, per-master
// drivers that push expected responses into scoreboard queues, and a
// monitor that pops and compares on every master_ready pulse.
module tb_uibi_arbiter;
    import uibi_pkg::*;

    localparam int XL = 32;
    localparam int SW = 4;
    localparam int AW = XL - SW;
    localparam int MN = 2;
    localparam int SN = 8;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [MN*XL-1:0]  master_dat_i, master_dat_o;
    logic [MN*AW-1:0]  master_addr;
    logic [MN*SW-1:0]  master_num;
    logic [MN-1:0]     master_req, master_wen, master_ready;
    logic [MN*3-1:0]   master_mode;
    logic [SN*XL-1:0]  slave_dat_o, slave_dat_i;
    logic [SN*AW-1:0]  slave_addr;
    logic [SN-1:0]     slave_req, slave_wen, slave_ready;
    logic [SN*3-1:0]   slave_mode;

    uibi_arbiter #(.XLEN(XL), .SLAVE_WIDTH(SW), .MASTER_NUM(MN), .SLAVE_NUM(SN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .master_dat_i(master_dat_i), .master_dat_o(master_dat_o), .master_addr(master_addr),
        .master_num(master_num), .master_req(master_req), .master_wen(master_wen),
        .master_mode(master_mode), .master_ready(master_ready),
        .slave_dat_o(slave_dat_o), .slave_dat_i(slave_dat_i), .slave_addr(slave_addr),
        .slave_req(slave_req), .slave_wen(slave_wen), .slave_mode(slave_mode),
        .slave_ready(slave_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- master-side drive ----------------
    logic          m_req [MN];
    logic          m_wen [MN];
    logic [SW-1:0] m_num [MN];
    logic [2:0]    m_mode[MN];
    logic [AW-1:0] m_addr[MN];
    logic [XL-1:0] m_dat [MN];

    always_comb begin
        master_req = '0; master_wen = '0; master_num = '0;
        master_mode = '0; master_addr = '0; master_dat_i = '0;
        for (int m = 0; m < MN; m++) begin
            master_req[m]            = m_req[m];
            master_wen[m]            = m_wen[m];
            master_num[m*SW +: SW]   = m_num[m];
            master_mode[m*3 +: 3]    = m_mode[m];
            master_addr[m*AW +: AW]  = m_addr[m];
            master_dat_i[m*XL +: XL] = m_dat[m];
        end
    end

    // ---------------- slave models ----------------
    int            sl_lat[SN];   // extra cycles before ready; > TO means never in time
    logic [XL-1:0] sl_dat[SN];
    int            sl_cnt[SN];
    logic [SN-1:0] noise;
    logic          noise_en;

    always_ff @(posedge clk) begin
        for (int s = 0; s < SN; s++) sl_cnt[s] <= slave_req[s] ? sl_cnt[s] + 1 : 0;
    end

    always_ff @(negedge clk) noise <= SN'($urandom);

    always_comb begin
        slave_ready = '0;
        slave_dat_i = '0;
        for (int s = 0; s < SN; s++) begin
            slave_dat_i[s*XL +: XL] = sl_dat[s];
            if (slave_req[s]) slave_ready[s] = (sl_cnt[s] == sl_lat[s]);
            else slave_ready[s] = noise_en & noise[s];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [SW-1:0] num;
        logic [AW-1:0] addr;
        logic          wen;
        logic [2:0]    mode;
        logic [XL-1:0] wdat;
        logic [XL-1:0] rdata;
        int            req_cycles;
        int            latency;
        int            issue;
        bit            solo;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   order[$];

    function automatic exp_t model(input logic [SW-1:0] num, input logic wen, input logic [2:0] mode,
                                   input logic [AW-1:0] addr, input logic [XL-1:0] dat, input bit solo);
        exp_t e;
        int   idx;
        int   eff;
        idx = int'(num);
        e.num = num; e.addr = addr; e.wen = wen; e.mode = mode; e.wdat = dat;
        e.issue = cyc; e.solo = solo;
        if (idx >= SN) begin
            e.rdata = '0; e.req_cycles = 0; e.latency = 1;
        end else begin
            if (sl_lat[idx] > TO) begin
                eff = TO; e.rdata = '0;
            end else begin
                eff = sl_lat[idx];
                e.rdata = wen ? 32'h0 : sl_dat[idx];
            end
            e.req_cycles = eff + 1;
            e.latency    = eff + 2;
        end
        return e;
    endfunction

    task automatic issue(input int m, input logic [SW-1:0] num, input logic wen, input logic [2:0] mode,
                         input logic [AW-1:0] addr, input logic [XL-1:0] dat, input bit solo);
        exp_t e;
        bit   got;
        @(negedge clk);
        m_num[m] = num; m_wen[m] = wen; m_mode[m] = mode;
        m_addr[m] = addr; m_dat[m] = dat; m_req[m] = 1'b1;
        e = model(num, wen, mode, addr, dat, solo);
        if (m == 0) q0.push_back(e); else q1.push_back(e);
        got = 1'b0;
        for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            got = master_ready[m];
        end
        m_req[m] = 1'b0;
        check($sformatf("ready_seen_m%0d", m), 64'(got), 64'd1);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int            req_cnt, first_req, sel, mi, qs;
        bit            unstable;
        logic [SW-1:0] c_num;
        logic [AW-1:0] c_addr;
        logic          c_wen;
        logic [2:0]    c_mode;
        logic [XL-1:0] c_dat;
        exp_t          e;
        req_cnt = 0; unstable = 1'b0; first_req = 0;
        c_num = '0; c_addr = '0; c_wen = 1'b0; c_mode = '0; c_dat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_cnt = 0; unstable = 1'b0;
            end else begin
                if (slave_req != '0) begin
                    check("slave_req_onehot", 64'($countones(slave_req)), 64'd1);
                    sel = 0;
                    for (int s = 0; s < SN; s++) if (slave_req[s]) sel = s;
                    if (req_cnt == 0) begin
                        first_req = cyc; c_num = SW'(sel);
                        c_addr = slave_addr[sel*AW +: AW]; c_wen = slave_wen[sel];
                        c_mode = slave_mode[sel*3 +: 3]; c_dat = slave_dat_o[sel*XL +: XL];
                    end else if (c_num != SW'(sel) || c_addr != slave_addr[sel*AW +: AW] ||
                                 c_wen != slave_wen[sel] || c_mode != slave_mode[sel*3 +: 3] ||
                                 c_dat != slave_dat_o[sel*XL +: XL]) begin
                        unstable = 1'b1;
                    end
                    req_cnt++;
                end
                if (master_ready != '0) begin
                    check("master_ready_onehot", 64'($countones(master_ready)), 64'd1);
                    mi = master_ready[1] ? 1 : 0;
                    qs = (mi == 0) ? q0.size() : q1.size();
                    check($sformatf("ready_expected_m%0d", mi), 64'(qs > 0), 64'd1);
                    if (qs > 0) begin
                        e = (mi == 0) ? q0.pop_front() : q1.pop_front();
                        check("rdata", 64'(master_dat_o[mi*XL +: XL]), 64'(e.rdata));
                        check("slave_req_cycles", 64'(req_cnt), 64'(e.req_cycles));
                        if (e.req_cycles > 0) begin
                            check("slave_sel", 64'(c_num), 64'(e.num));
                            check("slave_addr", 64'(c_addr), 64'(e.addr));
                            check("slave_wen", 64'(c_wen), 64'(e.wen));
                            check("slave_mode", 64'(c_mode), 64'(e.mode));
                            check("slave_wdat", 64'(c_dat), 64'(e.wdat));
                            check("fields_stable", 64'(unstable), 64'd0);
                            if (e.solo) check("first_req_cycle", 64'(first_req - e.issue), 64'd1);
                        end
                        if (e.solo) check("latency", 64'(cyc - e.issue), 64'(e.latency));
                    end
                    order.push_back(mi);
                    req_cnt = 0; unstable = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [2:0] modes[3];
        modes[0] = UIBI_MODE_WORD; modes[1] = UIBI_MODE_HALF; modes[2] = UIBI_MODE_BYTE;
        rst = 1'b1; noise_en = 1'b0;
        for (int m = 0; m < MN; m++) begin
            m_req[m] = 1'b0; m_wen[m] = 1'b0; m_num[m] = '0;
            m_mode[m] = '0; m_addr[m] = '0; m_dat[m] = '0;
        end
        for (int s = 0; s < SN; s++) begin sl_lat[s] = 0; sl_dat[s] = '0; end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_master_ready", 64'(master_ready), 64'd0);
        check("rst_master_dat", 64'(master_dat_o), 64'd0);
        check("rst_slave_req", 64'(slave_req), 64'd0);
        check("rst_slave_wen", 64'(slave_wen), 64'd0);
        check("rst_slave_mode", 64'(slave_mode), 64'd0);
        check("rst_slave_addr_or", 64'(|slave_addr), 64'd0);
        check("rst_slave_dat_or", 64'(|slave_dat_o), 64'd0);
        rst = 1'b0;

        // First read after reset, then an unmapped access returning 0
        sl_dat[2] = 32'h1234_5678; sl_lat[2] = 0;
        issue(1, 4'd2, 1'b0, UIBI_MODE_WORD, 28'h000_0ABC, 32'h0, 1'b1);
        issue(0, 4'd15, 1'b0, UIBI_MODE_WORD, 28'h000_0123, 32'h0, 1'b1);

        // Round-robin with both masters requesting continuously
        sl_lat[0] = 0; sl_lat[1] = 0; sl_dat[0] = 32'h0000_AAAA; sl_dat[1] = 32'h0000_BBBB;
        order.delete();
        fork
            begin for (int i = 0; i < 4; i++) issue(0, 4'd0, 1'b0, UIBI_MODE_WORD, AW'(i), 32'h0, 1'b0); end
            begin for (int i = 0; i < 4; i++) issue(1, 4'd1, 1'b0, UIBI_MODE_WORD, AW'(i + 16), 32'h0, 1'b0); end
        join
        @(negedge clk);
        check("rr_count", 64'(order.size()), 64'd8);
        for (int i = 1; i < order.size(); i++) check("rr_alternate", 64'(order[i] != order[i-1]), 64'd1);

        // Stalled slave at the longest non-timeout stall, write
        sl_lat[3] = TO; sl_dat[3] = 32'hDEAD_BEEF;
        issue(0, 4'd3, 1'b1, UIBI_MODE_BYTE, 28'h000_0055, 32'hA5A5_A5A5, 1'b1);

        // Timeout, then a normal request
        sl_lat[5] = 99; sl_dat[5] = 32'hCAFE_F00D;
        issue(1, 4'd5, 1'b0, UIBI_MODE_WORD, 28'h000_0777, 32'h0, 1'b1);
        sl_lat[6] = 1; sl_dat[6] = 32'h0BAD_F00D;
        issue(1, 4'd6, 1'b0, UIBI_MODE_HALF, 28'h000_0888, 32'h0, 1'b1);

        // Reset in the middle of a master-0 access: dropped, priority back to master 0
        sl_lat[4] = 99;
        @(negedge clk);
        m_num[0] = 4'd4; m_wen[0] = 1'b0; m_mode[0] = UIBI_MODE_WORD; m_req[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_busy_req", 64'(slave_req), 64'h10);
        rst = 1'b1; m_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_slave_req", 64'(slave_req), 64'd0);
        check("mid_rst_master_ready", 64'(master_ready), 64'd0);
        order.delete();
        fork
            issue(0, 4'd0, 1'b0, UIBI_MODE_WORD, 28'h000_0001, 32'h0, 1'b0);
            issue(1, 4'd1, 1'b0, UIBI_MODE_WORD, 28'h000_0002, 32'h0, 1'b0);
        join
        @(negedge clk);
        check("post_rst_first_grant", 64'(order.size() > 0 ? order[0] : 9), 64'd0);

        // Randomised traffic with noise on unselected slave_ready lines
        for (int s = 0; s < SN; s++) begin
            sl_lat[s] = $urandom_range(0, 6);
            sl_dat[s] = $urandom;
        end
        noise_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    issue(0, ($urandom_range(0, 3) == 0) ? SW'($urandom_range(8, 15)) : SW'($urandom_range(0, 7)),
                          1'($urandom), modes[$urandom_range(0, 2)], AW'($urandom), $urandom, 1'b0);
                end
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    issue(1, ($urandom_range(0, 3) == 0) ? SW'($urandom_range(8, 15)) : SW'($urandom_range(0, 7)),
                          1'($urandom), modes[$urandom_range(0, 2)], AW'($urandom), $urandom, 1'b0);
                end
            end
        join
        noise_en = 1'b0;
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
